spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI master that turns command/data transactions into 11-bit SPI frames for the spi_wrapper slave.
//  It drives ss_n/mosi, samples miso during read-data frames, and returns the read byte on a response port.
//  It sits directly upstream of spi_wrapper, replacing hand-driven bench stimulus in system-level use.
// PARAMETERS
//  LEAD_CYCLES  1  cycles ss_n is low with mosi=0 before frame bit 10 is driven (1..4)
//  RD_LATENCY   2  cycles after frame bit 0 before the first miso sample on a RD_DATA frame (0..15)
//  GAP_CYCLES   2  minimum cycles ss_n is held high between frames (>=1)
// PORTS
//  clk        in   1  clock; all logic on posedge
//  rst        in   1  synchronous reset, active-high
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  block can accept a command; high only in IDLE
//  cmd_op     in   2  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//  cmd_data   in   8  frame payload (address/data); ignored (sent as 0) for RD_DATA
//  rsp_valid  out  1  one-cycle pulse: rsp_data holds a new read byte
//  rsp_data   out  8  last byte read from miso; held until the next RD_DATA completes
//  ss_n       out  1  slave select, active-low
//  mosi       out  1  serial data to slave, MSB first
//  miso       in   1  serial data from slave
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset values: ss_n=1, mosi=0, cmd_ready=0 in the reset cycle (1 from the first cycle after), rsp_valid=0, rsp_data=8'h00, busy=0.
//  Frame = {code[2:0], payload[7:0]}; code: WR_ADDR=000, WR_DATA=001, RD_ADDR=110, RD_DATA=111.
//  Handshake: accept on posedge with cmd_valid && cmd_ready (cycle T). The frame register is loaded at T; cmd_* are not sampled afterwards.
//  FSM states: IDLE -> LEAD -> SHIFT -> (RD_DATA ? WAIT -> READ) -> GAP -> IDLE.
//   LEAD: ss_n=0 and mosi=0 for LEAD_CYCLES cycles (T+1 .. T+LEAD_CYCLES).
//   SHIFT: 11 cycles; bits 10..0 appear on mosi, one bit per cycle, with ss_n=0.
//   WAIT: RD_DATA only; RD_LATENCY cycles with ss_n=0 and mosi=0. If RD_LATENCY=0, skip straight to READ.
//   READ: 8 cycles; miso sampled on each posedge, MSB first, with ss_n=0.
//     The cycle after the 8th sample: rsp_data updated, rsp_valid=1 for exactly one cycle, ss_n=1, state=GAP.
//   GAP: ss_n=1, mosi=0 for GAP_CYCLES cycles, then IDLE.
//  Latency (accept to ss_n rising):
//   non-read: LEAD_CYCLES+11 cycles
//   RD_DATA: LEAD_CYCLES+11+RD_LATENCY+8 cycles.
//  Next accept occurs no earlier than ss_n rise + GAP_CYCLES.
//  Back-to-back cmd_valid: held off by cmd_ready=0; no queuing, no drop of an accepted command.
//  rsp_valid never asserts for WR_ADDR/WR_DATA/RD_ADDR. miso is ignored outside READ.
//  Reset mid-frame: next edge forces IDLE, ss_n=1, rsp_valid=0; a partial read is discarded and rsp_data is cleared to 0.
//  Bit counter: 4 bits, counts 10 down to 0; the down-count wraps to 15 only on the exit cycle, which is ignored.
//  cmd_valid while rst=1 is ignored.
// STRUCTURE
//  spi_pkg:
//   - op_e enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA)
//   - localparam frame codes (3'b000/001/110/111), FRAME_W=11, DATA_W=8
//   - state_e enum (IDLE, LEAD, SHIFT, WAIT, READ, GAP)
//  Sub-module spi_master_shifter: 11-bit PISO for mosi, 8-bit SIPO for miso, and shared bit counter.
//  Control: load/shift/capture strobes driven by the FSM in spi_master_ctrl.
// TESTING
//  1. Reset: rst=1 for 3 cycles mid RD_DATA READ -> next cycle ss_n=1, busy=0, rsp_valid never pulses, rsp_data=00.
//  2. WR_ADDR 8'hA5, defaults: mosi bits 1-11 after lead = 0,0,0,1,0,1,0,0,1,0,1; ss_n low for exactly 12 cycles; no rsp_valid.
//  3. WR_ADDR 8'h3C, WR_DATA 8'h5A, RD_ADDR 8'h3C, then RD_DATA, against spi_wrapper -> one rsp_valid pulse with rsp_data=8'h5A.
//  4. cmd_valid held high for 4 consecutive WR_DATA: cmd_ready drops on accept; ss_n is high >=2 cycles between frames; exactly 4 frames.
//  5. RD_DATA with RD_LATENCY=0 and miso driven with pattern 8'hC3 -> rsp_data=8'hC3; ss_n low for 1+11+8=20 cycles.
//  6. Random 2000-command run vs a scoreboard model (addr->data map): every rsp_data matches the last write to the last read address.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: command opcodes, frame codes and FSM states.
package spi_pkg;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  localparam logic [2:0] CODE_WR_ADDR = 3'b000;
  localparam logic [2:0] CODE_WR_DATA = 3'b001;
  localparam logic [2:0] CODE_RD_ADDR = 3'b110;
  localparam logic [2:0] CODE_RD_DATA = 3'b111;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    WAIT,
    READ,
    GAP
  } state_e;

  function automatic logic [2:0] op_code(input op_e op);
    logic [2:0] code;
    code = CODE_WR_ADDR;
    unique case (op)
      WR_ADDR: code = CODE_WR_ADDR;
      WR_DATA: code = CODE_WR_DATA;
      RD_ADDR: code = CODE_RD_ADDR;
      RD_DATA: code = CODE_RD_DATA;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: 11-bit PISO toward mosi, SIPO from miso and the shared bit counter.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               shift,
  input  logic               capture,
  input  logic               miso,
  input  logic               cnt_load,
  input  logic [CNT_W-1:0]   cnt_init,
  input  logic               cnt_dec,
  output logic               tx_bit,
  output logic [DATA_W-1:0]  rx_byte,
  output logic [CNT_W-1:0]   cnt
);

  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-2:0]  rx_q;
  logic [CNT_W-1:0]   cnt_q;

  // The eighth bit is taken straight from miso so the full byte is visible on the last sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load)
        tx_q <= frame;
      else if (shift)
        tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
      if (capture)
        rx_q <= {rx_q[DATA_W-3:0], miso};
      if (cnt_load)
        cnt_q <= cnt_init;
      else if (cnt_dec)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tx_bit  = tx_q[FRAME_W-1];
  assign rx_byte = {rx_q, miso};
  assign cnt     = cnt_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: accepts one command at a time, frames it as {code, payload} and
// returns the byte read back on RD_DATA frames.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int LEAD_CYCLES = 1,
  parameter int RD_LATENCY  = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso,
  output logic              busy
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] LEAD_INIT = TMR_W'(LEAD_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_INIT = TMR_W'(RD_LATENCY - 1);
  localparam logic [TMR_W-1:0] GAP_INIT  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_READ  = CNT_W'(DATA_W - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_init;
  logic               tmr_load;
  logic               rd_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               accept;
  op_e                op;
  logic [FRAME_W-1:0] frame_d;
  logic               frame_load, shift_en, capture_en, cnt_load, cnt_dec, rsp_fire;
  logic [CNT_W-1:0]   cnt_init, cnt;
  logic               tx_bit;
  logic [DATA_W-1:0]  rx_byte;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign frame_d   = {op_code(op), (op == RD_DATA) ? {DATA_W{1'b0}} : cmd_data};

  spi_master_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (frame_load),
    .frame    (frame_d),
    .shift    (shift_en),
    .capture  (capture_en),
    .miso     (miso),
    .cnt_load (cnt_load),
    .cnt_init (cnt_init),
    .cnt_dec  (cnt_dec),
    .tx_bit   (tx_bit),
    .rx_byte  (rx_byte),
    .cnt      (cnt)
  );

  // A general timer paces LEAD, WAIT and GAP; the shifter counter paces SHIFT and READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (tmr_load)
        tmr_q <= tmr_init;
      else if (tmr_q != '0)
        tmr_q <= tmr_q - TMR_W'(1);
      if (accept)
        rd_q <= (op == RD_DATA);
      rsp_valid_q <= rsp_fire;
      if (rsp_fire)
        rsp_data_q <= rx_byte;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_init   = LEAD_INIT;
    frame_load = 1'b0;
    shift_en   = 1'b0;
    capture_en = 1'b0;
    cnt_load   = 1'b0;
    cnt_init   = CNT_SHIFT;
    cnt_dec    = 1'b0;
    rsp_fire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          frame_load = 1'b1;
          tmr_load   = 1'b1;
          tmr_init   = LEAD_INIT;
          state_d    = LEAD;
        end
      end
      LEAD: begin
        if (tmr_q == '0) begin
          cnt_load = 1'b1;
          cnt_init = CNT_SHIFT;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_dec  = 1'b1;
        if (cnt == '0) begin
          if (!rd_q) begin
            tmr_load = 1'b1;
            tmr_init = GAP_INIT;
            state_d  = GAP;
          end else if (RD_LATENCY == 0) begin
            cnt_load = 1'b1;
            cnt_init = CNT_READ;
            state_d  = READ;
          end else begin
            tmr_load = 1'b1;
            tmr_init = WAIT_INIT;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (tmr_q == '0) begin
          cnt_load = 1'b1;
          cnt_init = CNT_READ;
          state_d  = READ;
        end
      end
      READ: begin
        capture_en = 1'b1;
        cnt_dec    = 1'b1;
        if (cnt == '0) begin
          rsp_fire = 1'b1;
          tmr_load = 1'b1;
          tmr_init = GAP_INIT;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (tmr_q == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ss_n      = !(state_q inside {LEAD, SHIFT, WAIT, READ});
  assign mosi      = (state_q == SHIFT) ? tx_bit : 1'b0;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural spi_wrapper slave and an addr->data scoreboard.
module tb_spi_master_ctrl;

  localparam int L    = 1;
  localparam int RDL  = 2;
  localparam int GAPC = 2;
  localparam int RD0  = L + 11 + RDL;
  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, rsp_valid, ss_n, mosi, miso, busy;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data;
  logic       cmd_valid0, cmd_ready0, rsp_valid0, ss_n0, mosi0, miso0, busy0;
  logic [1:0] cmd_op0;
  logic [7:0] cmd_data0, rsp_data0;

  int vectors = 0;
  int miscompares = 0;
  logic mon_clear = 1'b0;

  int rsp_count = 0, frames = 0, low_run = 0, high_run = 0, last_low = 0, min_gap = 99;
  int low_run0 = 0, last_low0 = 0, rsp_count0 = 0;
  logic [7:0] pat0 = 8'hC3;

  logic [7:0]  sl_mem [256] = '{default: 8'h00};
  logic [7:0]  sl_addr = 8'h00, sl_rd = 8'h00;
  logic [10:0] sl_frame = '0, sl_last_frame = '0;
  int          sl_k = 0;
  logic        sl_lead_bad = 1'b0;

  logic [7:0]   sb_mem [256];
  logic [255:0] sb_valid;
  logic [7:0]   sb_addr;

  spi_master_ctrl #(.LEAD_CYCLES(L), .RD_LATENCY(RDL), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .busy(busy)
  );

  spi_master_ctrl #(.LEAD_CYCLES(1), .RD_LATENCY(0), .GAP_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_op(cmd_op0),
    .cmd_data(cmd_data0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .ss_n(ss_n0),
    .mosi(mosi0), .miso(miso0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame-level monitor on the main instance: ss_n low/high run lengths and response pulses.
  always @(negedge clk) begin
    if (mon_clear) begin
      rsp_count = 0; frames = 0; low_run = 0; high_run = 0; min_gap = 99;
    end else begin
      if (rsp_valid === 1'b1) rsp_count++;
      if (ss_n === 1'b0) begin
        if (high_run != 0 && frames != 0 && high_run < min_gap) min_gap = high_run;
        high_run = 0;
        low_run++;
      end else begin
        if (low_run != 0) begin
          last_low = low_run;
          frames++;
        end
        low_run = 0;
        high_run++;
      end
    end
  end

  // Behavioural spi_wrapper: decodes frames after the lead-in, answers RD_DATA on miso.
  always @(negedge clk) begin
    if (mon_clear) sl_lead_bad = 1'b0;
    if (rst || ss_n !== 1'b0) begin
      sl_k = 0;
      miso = 1'b0;
    end else begin
      if (sl_k < L && mosi !== 1'b0) sl_lead_bad = 1'b1;
      if (sl_k >= L && sl_k < L + 11) begin
        sl_frame = {sl_frame[9:0], mosi};
        if (sl_k == L + 10) begin
          sl_last_frame = sl_frame;
          case (sl_frame[10:8])
            3'b000, 3'b110: sl_addr = sl_frame[7:0];
            3'b001:         sl_mem[sl_addr] = sl_frame[7:0];
            3'b111:         sl_rd = sl_mem[sl_addr];
            default: ;
          endcase
        end
      end
      if (sl_k >= RD0 && sl_k < RD0 + 8) miso = sl_rd[7 - (sl_k - RD0)];
      else miso = 1'b0;
      sl_k++;
    end
  end

  // Zero-latency instance: plays pattern 8'hC3 during its READ window.
  always @(negedge clk) begin
    if (rst) begin
      low_run0 = 0; last_low0 = 0; rsp_count0 = 0; miso0 = 1'b0;
    end else begin
      if (rsp_valid0 === 1'b1) rsp_count0++;
      if (ss_n0 === 1'b0) begin
        if (low_run0 >= 12 && low_run0 < 20) miso0 = pat0[7 - (low_run0 - 12)];
        else miso0 = 1'b0;
        low_run0++;
      end else begin
        if (low_run0 != 0) last_low0 = low_run0;
        low_run0 = 0;
        miso0 = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) checkOutput("accept_timeout", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", {31'd0, busy}, 0);
    @(negedge clk);
  endtask

  task automatic clearMon();
    @(posedge clk);
    #1 mon_clear = 1'b1;
    @(negedge clk);
    #1 mon_clear = 1'b0;
  endtask

  task automatic waitRsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1) checkOutput("rsp_timeout", {31'd0, rsp_valid}, 1);
  endtask

  initial begin
    int n, acc;
    logic [1:0] op;
    logic [7:0] d;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    cmd_valid0 = 1'b0; cmd_op0 = 2'b00; cmd_data0 = 8'h00;
    sb_valid = '0; sb_addr = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ss_n", {31'd0, ss_n}, 1);
    checkOutput("rst_mosi", {31'd0, mosi}, 0);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    checkOutput("rst_rsp_data", {24'd0, rsp_data}, 8'h00);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'd0, cmd_ready}, 1);
    checkOutput("ready_after_rst0", {31'd0, cmd_ready0}, 1);

    $display("[TB] WR_ADDR A5 framing");
    clearMon();
    applyStimulus(OP_WA, 8'hA5);
    waitIdle();
    checkOutput("wa_frame_bits", {21'd0, sl_last_frame}, 11'h0A5);
    checkOutput("wa_ss_low_len", last_low, L + 11);
    checkOutput("wa_no_rsp", rsp_count, 0);
    checkOutput("wa_frame_count", frames, 1);
    checkOutput("wa_lead_mosi_low", {31'd0, sl_lead_bad}, 0);

    $display("[TB] write then read back through slave");
    clearMon();
    applyStimulus(OP_WA, 8'h3C);
    applyStimulus(OP_WD, 8'h5A);
    applyStimulus(OP_RA, 8'h3C);
    applyStimulus(OP_RD, 8'h77);
    waitIdle();
    checkOutput("rd_rsp_count", rsp_count, 1);
    checkOutput("rd_rsp_data", {24'd0, rsp_data}, 8'h5A);
    checkOutput("rd_frame_count", frames, 4);
    checkOutput("rd_payload_zero", {21'd0, sl_last_frame}, 11'h700);
    checkOutput("rd_ss_low_len", last_low, L + 11 + RDL + 8);

    $display("[TB] reset during READ");
    clearMon();
    applyStimulus(OP_RD, 8'h00);
    repeat (17) @(negedge clk);
    checkOutput("mid_read_ss_low", {31'd0, ss_n}, 0);
    checkOutput("mid_read_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ss_n", {31'd0, ss_n}, 1);
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_rsp_data", {24'd0, rsp_data}, 8'h00);
    checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_rsp", rsp_count, 0);
    checkOutput("abort_rsp_data_held", {24'd0, rsp_data}, 8'h00);
    checkOutput("abort_ready", {31'd0, cmd_ready}, 1);

    $display("[TB] cmd_valid held for four WR_DATA");
    clearMon();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_WD; cmd_data = 8'h10;
    acc = 0; n = 0;
    while (acc < 4 && n < 400) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        acc++;
        @(negedge clk);
        checkOutput("b2b_ready_drop", {31'd0, cmd_ready}, 0);
        cmd_data = 8'h10 + 8'(acc);
        if (acc == 4) cmd_valid = 1'b0;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    cmd_valid = 1'b0;
    checkOutput("b2b_accepts", acc, 4);
    waitIdle();
    checkOutput("b2b_frame_count", frames, 4);
    checkOutput("b2b_gap_ge2", {31'd0, min_gap >= 2}, 1);
    checkOutput("b2b_last_frame", {21'd0, sl_last_frame}, 11'h113);

    $display("[TB] RD_DATA with zero read latency");
    @(negedge clk);
    cmd_valid0 = 1'b1; cmd_op0 = OP_RD; cmd_data0 = 8'hFF;
    n = 0;
    while (cmd_ready0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_valid0 = 1'b0;
    n = 0;
    while (rsp_valid0 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd0_rsp_seen", {31'd0, rsp_valid0}, 1);
    checkOutput("rd0_rsp_data", {24'd0, rsp_data0}, 8'hC3);
    repeat (3) @(negedge clk);
    checkOutput("rd0_ss_low_len", last_low0, 20);
    checkOutput("rd0_rsp_count", rsp_count0, 1);

    $display("[TB] random command run against scoreboard");
    for (int i = 0; i < 2000; i++) begin
      op = (i == 0) ? OP_WA : 2'($urandom_range(3));
      if (op == OP_RD && !sb_valid[sb_addr]) op = OP_WD;
      if (op == OP_WD) d = 8'($urandom_range(255));
      else d = 8'($urandom_range(15));
      case (op)
        OP_WA, OP_RA: sb_addr = d;
        OP_WD: begin
          sb_mem[sb_addr] = d;
          sb_valid[sb_addr] = 1'b1;
        end
        default: ;
      endcase
      applyStimulus(op, d);
      if (op == OP_RD) begin
        waitRsp();
        checkOutput("rand_rd_data", {24'd0, rsp_data}, {24'd0, sb_mem[sb_addr]});
      end
    end
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
